// File: rtl/seed_pkg.sv
// rtl/seed_pkg.sv - shared types and constants for the SEED F-function block
package seed_pkg;

   localparam int WORD   = 32;
   localparam int HALF   = 64;
   localparam int G_ITER = 1;
   localparam int G_PIPE = 3;

   // Low byte of the field polynomial x^8+x^6+x^5+x+1
   localparam logic [7:0] GF_POLY = 8'h63;

   localparam logic [7:0] M0 = 8'hFC;
   localparam logic [7:0] M1 = 8'hF3;
   localparam logic [7:0] M2 = 8'hCF;
   localparam logic [7:0] M3 = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      G0,
      G1,
      G2,
      HOLD
   } fsm_t;

endpackage

// File: rtl/seed_f_pipe_g.sv
// rtl/seed_f_pipe_g.sv - SEED G-function: per-byte GF(2^8) power S-boxes and masked byte mixing
module seed_f_pipe_g
   import seed_pkg::*;
(
   input  logic [WORD-1:0] i_X,
   output logic [WORD-1:0] o_Z
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ GF_POLY) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_pow(input logic [7:0] a, input logic [7:0] e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, a);
      end
      return r;
   endfunction

   function automatic logic [7:0] rol(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] s1(input logic [7:0] a);
      logic [7:0] p;
      p = gf_pow(a, 8'd247);
      return p ^ rol(p, 1) ^ rol(p, 2) ^ rol(p, 3) ^ rol(p, 4) ^ 8'hA9;
   endfunction

   function automatic logic [7:0] s2(input logic [7:0] a);
      logic [7:0] p;
      p = gf_pow(a, 8'd251);
      return p ^ rol(p, 1) ^ rol(p, 3) ^ rol(p, 4) ^ rol(p, 6) ^ 8'h38;
   endfunction

   logic [7:0] w_y0, w_y1, w_y2, w_y3;

   assign w_y0 = s1(i_X[7:0]);
   assign w_y1 = s2(i_X[15:8]);
   assign w_y2 = s1(i_X[23:16]);
   assign w_y3 = s2(i_X[31:24]);

   assign o_Z[7:0]   = (w_y0 & M0) ^ (w_y1 & M1) ^ (w_y2 & M2) ^ (w_y3 & M3);
   assign o_Z[15:8]  = (w_y0 & M1) ^ (w_y1 & M2) ^ (w_y2 & M3) ^ (w_y3 & M0);
   assign o_Z[23:16] = (w_y0 & M2) ^ (w_y1 & M3) ^ (w_y2 & M0) ^ (w_y3 & M1);
   assign o_Z[31:24] = (w_y0 & M3) ^ (w_y1 & M0) ^ (w_y2 & M1) ^ (w_y3 & M2);

endmodule

// File: rtl/seed_f_pipe.sv
// rtl/seed_f_pipe.sv - SEED F-function, iterative (G_UNITS=1) or 3-stage pipelined (G_UNITS=3)
// Optional output-transfer counter o_OpCnt enabled by SEED_F_OPCNT_EN.
module seed_f_pipe
   import seed_pkg::*;
#(
   parameter int G_UNITS = 3
) (
   input  logic            i_Clk,
   input  logic            i_Rst_n,
   input  logic            i_Valid,
   output logic            o_Ready,
   input  logic [HALF-1:0] i_Data,
   input  logic [HALF-1:0] i_Key,
   output logic            o_Valid,
   input  logic            i_Ready,
   output logic [HALF-1:0] o_Data,
`ifdef SEED_F_OPCNT_EN
   output logic [15:0]     o_OpCnt,
`endif
   output logic            o_Busy
);

   logic [WORD-1:0] w_c;
   logic [WORD-1:0] w_d;
   logic            w_in_xfer;

   assign w_c       = i_Data[HALF-1:WORD] ^ i_Key[HALF-1:WORD];
   assign w_d       = i_Data[WORD-1:0] ^ i_Key[WORD-1:0];
   assign w_in_xfer = i_Valid && o_Ready;

   generate
      if (G_UNITS == G_ITER) begin : g_iter
         fsm_t            r_state;
         logic            r_idle;
         logic            r_valid;
         logic [WORD-1:0] r_c, r_d, r_t0, r_t1;
         logic [HALF-1:0] r_out;
         logic [WORD-1:0] w_gx, w_gz;

         // One shared G unit; its operand follows the round being evaluated
         always_comb begin
            case (r_state)
               G1:      w_gx = r_c + r_t0;
               G2:      w_gx = r_t1 + r_t0;
               default: w_gx = r_c ^ r_d;
            endcase
         end

         seed_f_pipe_g u_g (.i_X(w_gx), .o_Z(w_gz));

         always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
               r_state <= IDLE;
               r_idle  <= 1'b1;
               r_valid <= 1'b0;
               r_c     <= '0;
               r_d     <= '0;
               r_t0    <= '0;
               r_t1    <= '0;
               r_out   <= '0;
            end else begin
               case (r_state)
                  IDLE: if (w_in_xfer) begin
                     r_c     <= w_c;
                     r_d     <= w_d;
                     r_idle  <= 1'b0;
                     r_state <= G0;
                  end
                  G0: begin
                     r_t0    <= w_gz;
                     r_state <= G1;
                  end
                  G1: begin
                     r_t1    <= w_gz;
                     r_state <= G2;
                  end
                  G2: begin
                     r_out   <= {r_t1 + w_gz, w_gz};
                     r_valid <= 1'b1;
                     r_state <= HOLD;
                  end
                  HOLD: if (i_Ready) begin
                     r_valid <= 1'b0;
                     r_idle  <= 1'b1;
                     r_state <= IDLE;
                  end
                  default: r_state <= IDLE;
               endcase
            end
         end

         assign o_Ready = i_Rst_n && r_idle;
         assign o_Valid = r_valid;
         assign o_Data  = r_out;
         assign o_Busy  = !r_idle;
      end else if (G_UNITS == G_PIPE) begin : g_pipe
         logic            r_v1, r_v2, r_v3;
         logic [WORD-1:0] r_c1, r_t0_1, r_t0_2, r_t1_2;
         logic [HALF-1:0] r_out;
         logic [WORD-1:0] w_x0, w_x1, w_x2, w_z0, w_z1, w_z2;
         logic            w_adv;

         // Whole pipe moves together, so bubbles keep their slots
         assign w_adv = !r_v3 || i_Ready;
         assign w_x0  = w_c ^ w_d;
         assign w_x1  = r_c1 + r_t0_1;
         assign w_x2  = r_t1_2 + r_t0_2;

         seed_f_pipe_g u_g0 (.i_X(w_x0), .o_Z(w_z0));
         seed_f_pipe_g u_g1 (.i_X(w_x1), .o_Z(w_z1));
         seed_f_pipe_g u_g2 (.i_X(w_x2), .o_Z(w_z2));

         always_ff @(posedge i_Clk or negedge i_Rst_n) begin
            if (!i_Rst_n) begin
               r_v1   <= 1'b0;
               r_v2   <= 1'b0;
               r_v3   <= 1'b0;
               r_c1   <= '0;
               r_t0_1 <= '0;
               r_t0_2 <= '0;
               r_t1_2 <= '0;
               r_out  <= '0;
            end else if (w_adv) begin
               r_v1   <= w_in_xfer;
               r_v2   <= r_v1;
               r_v3   <= r_v2;
               r_c1   <= w_c;
               r_t0_1 <= w_z0;
               r_t0_2 <= r_t0_1;
               r_t1_2 <= w_z1;
               r_out  <= {r_t1_2 + w_z2, w_z2};
            end
         end

         assign o_Ready = i_Rst_n && w_adv;
         assign o_Valid = r_v3;
         assign o_Data  = r_out;
         assign o_Busy  = r_v1 || r_v2 || r_v3;
      end else begin : g_bad
         $fatal(1, "seed_f_pipe: G_UNITS must be 1 or 3");
      end
   endgenerate

`ifdef SEED_F_OPCNT_EN
   logic [15:0] r_opcnt;
   logic        w_out_xfer;

   assign w_out_xfer = o_Valid && i_Ready;

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_opcnt <= '0;
      end else if (w_out_xfer) begin
         r_opcnt <= r_opcnt + 16'd1;
      end
   end

   assign o_OpCnt = r_opcnt;
`endif

endmodule

// File: tb/tb_seed_f_pipe.sv
// tb/tb_seed_f_pipe.sv - bench for seed_f_pipe, iterative (index 0) and pipelined (index 1) instances
module tb_seed_f_pipe;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        v_in[2];
   logic [63:0] d_in[2];
   logic [63:0] k_in[2];
   logic        rdy_in[2];
   logic        rdy_o[2];
   logic        v_o[2];
   logic [63:0] d_o[2];
   logic        busy_o[2];
`ifdef SEED_F_OPCNT_EN
   logic [15:0] cnt_o[2];
`endif

   seed_f_pipe #(.G_UNITS(1)) u_iter (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v_in[0]), .o_Ready(rdy_o[0]),
      .i_Data(d_in[0]), .i_Key(k_in[0]), .o_Valid(v_o[0]), .i_Ready(rdy_in[0]),
      .o_Data(d_o[0]),
`ifdef SEED_F_OPCNT_EN
      .o_OpCnt(cnt_o[0]),
`endif
      .o_Busy(busy_o[0]));

   seed_f_pipe #(.G_UNITS(3)) u_pipe (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(v_in[1]), .o_Ready(rdy_o[1]),
      .i_Data(d_in[1]), .i_Key(k_in[1]), .o_Valid(v_o[1]), .i_Ready(rdy_in[1]),
      .o_Data(d_o[1]),
`ifdef SEED_F_OPCNT_EN
      .o_OpCnt(cnt_o[1]),
`endif
      .o_Busy(busy_o[1]));

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] exp_q[2][$];
   logic [63:0] obs_d[2][$];
   int          obs_t[2][$];

   always @(negedge clk) begin
      for (int s = 0; s < 2; s++)
         if (rst_n && v_o[s] && rdy_in[s]) begin
            obs_d[s].push_back(d_o[s]);
            obs_t[s].push_back(cyc);
         end
   end

   // Golden model, built from a carry-less multiply and repeated powering
   logic [7:0] s1t[256];
   logic [7:0] s2t[256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (a[i]) p = p ^ (16'(b) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h163 << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] w;
      w = {b, b};
      return w[15-n -: 8];
   endfunction

   task automatic build_tables();
      logic [7:0] p;
      logic [7:0] r;
      for (int x = 0; x < 256; x++) begin
         p = 8'h01;
         for (int k = 0; k < 247; k++) p = gmul(p, 8'(x));
         r = p;
         for (int n = 1; n <= 4; n++) r = r ^ rotl(p, n);
         s1t[x] = r ^ 8'hA9;
         p = 8'h01;
         for (int k = 0; k < 251; k++) p = gmul(p, 8'(x));
         s2t[x] = p ^ rotl(p, 1) ^ rotl(p, 3) ^ rotl(p, 4) ^ rotl(p, 6) ^ 8'h38;
      end
   endtask

   function automatic logic [31:0] g_model(input logic [31:0] x);
      logic [7:0] y[4];
      logic [7:0] m[4];
      logic [31:0] z;
      m[0] = 8'hFC; m[1] = 8'hF3; m[2] = 8'hCF; m[3] = 8'h3F;
      y[0] = s1t[x[7:0]];
      y[1] = s2t[x[15:8]];
      y[2] = s1t[x[23:16]];
      y[3] = s2t[x[31:24]];
      z = '0;
      for (int j = 0; j < 4; j++)
         for (int i = 0; i < 4; i++)
            z[8*j +: 8] = z[8*j +: 8] ^ (y[i] & m[(i + j) % 4]);
      return z;
   endfunction

   function automatic logic [63:0] f_model(input logic [63:0] d, input logic [63:0] k);
      logic [31:0] c, dd, t0, t1, t2, hi;
      c  = d[63:32] ^ k[63:32];
      dd = d[31:0] ^ k[31:0];
      t0 = g_model(c ^ dd);
      t1 = g_model(c + t0);
      t2 = g_model(t1 + t0);
      hi = t1 + t2;
      return {hi, t2};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, req);
      end
   endtask

   task automatic send(input int s, input logic [63:0] d, input logic [63:0] k);
      int n;
      n = 0;
      v_in[s] = 1'b1;
      d_in[s] = d;
      k_in[s] = k;
      @(negedge clk);
      while (!rdy_o[s] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 64'(n < 50), 64'd1);
      exp_q[s].push_back(f_model(d, k));
      @(posedge clk);
      #1;
      v_in[s] = 1'b0;
      d_in[s] = ~d;
      k_in[s] = {k[31:0], k[63:32]};
   endtask

   task automatic drain(input int s, input int gap);
      int n, cnt, t, tprev;
      logic [63:0] e, a;
      n = 0;
      tprev = 0;
      cnt = exp_q[s].size();
      while (obs_d[s].size() < cnt && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("result_count", 64'(obs_d[s].size()), 64'(cnt));
      for (int i = 0; i < cnt; i++) begin
         if (obs_d[s].size() == 0) break;
         e = exp_q[s].pop_front();
         a = obs_d[s].pop_front();
         t = obs_t[s].pop_front();
         chk("result_data", a, e);
         if (gap > 0 && i > 0) chk("result_spacing", 64'(t - tprev), 64'(gap));
         tprev = t;
      end
      repeat (12) @(posedge clk);
      #1;
      chk("no_extra_result", 64'(obs_d[s].size()), 64'd0);
      exp_q[s].delete();
      obs_d[s].delete();
      obs_t[s].delete();
   endtask

   typedef struct {
      logic [63:0] data;
      logic [63:0] key;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[5];

   task automatic single_op(input int s, input vec_t v);
      int lat;
      rdy_in[s] = 1'b1;
      v_in[s] = 1'b1;
      d_in[s] = v.data;
      k_in[s] = v.key;
      @(posedge clk);
      #1;
      v_in[s] = 1'b0;
      d_in[s] = ~v.data;
      k_in[s] = ~v.key;
      lat = 1;
      while (!v_o[s] && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 64'(lat), 64'((s == 1) ? 3 : 4));
      chk("single_data", d_o[s], v.exp);
      @(posedge clk);
      #1;
      chk("busy_after_op", 64'(busy_o[s]), 64'd0);
      obs_d[s].delete();
      obs_t[s].delete();
   endtask

   task automatic back_to_back(input int s);
      rdy_in[s] = 1'b1;
      for (int i = 0; i < 8; i++) send(s, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      drain(s, (s == 1) ? 1 : 5);
   endtask

   task automatic backpressure(input int s);
      int n;
      logic ok;
      logic [63:0] snap;
      rdy_in[s] = 1'b0;
      for (int i = 0; i < ((s == 1) ? 3 : 1); i++)
         send(s, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      n = 0;
      while (!v_o[s] && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("bp_valid", 64'(v_o[s]), 64'd1);
      snap = d_o[s];
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (d_o[s] !== snap || !v_o[s] || rdy_o[s]) ok = 1'b0;
      end
      chk("bp_hold_stable", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      rdy_in[s] = 1'b1;
      drain(s, 0);
   endtask

   task automatic reset_mid(input int s);
      rdy_in[s] = 1'b1;
      v_in[s] = 1'b1;
      d_in[s] = tbl[0].data;
      k_in[s] = tbl[0].key;
      @(posedge clk);
      #1;
      v_in[s] = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(v_o[s]), 64'd0);
      chk("rst_busy", 64'(busy_o[s]), 64'd0);
      chk("rst_data", d_o[s], 64'd0);
      chk("rst_ready", 64'(rdy_o[s]), 64'd0);
      for (int j = 0; j < 2; j++) begin
         exp_q[j].delete();
         obs_d[j].delete();
         obs_t[j].delete();
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", 64'(rdy_o[s]), 64'd1);
      @(posedge clk);
      #1;
      send(s, 64'd0, 64'd0);
      drain(s, 0);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         v_in[s] = 1'b0;
         d_in[s] = '0;
         k_in[s] = '0;
         rdy_in[s] = 1'b1;
      end
      build_tables();
      tbl[0].data = 64'h0123456789ABCDEF; tbl[0].key = 64'hFEDCBA9876543210;
      tbl[1].data = 64'hFFFFFFFF00000000; tbl[1].key = 64'h0;
      tbl[2].data = 64'h0;                tbl[2].key = 64'h0;
      tbl[3].data = {$urandom(), $urandom()}; tbl[3].key = {$urandom(), $urandom()};
      tbl[4].data = {$urandom(), $urandom()}; tbl[4].key = {$urandom(), $urandom()};
      for (int i = 0; i < 5; i++) tbl[i].exp = f_model(tbl[i].data, tbl[i].key);

      #2;
      rst_n = 1'b0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("reset_valid", 64'(v_o[s]), 64'd0);
         chk("reset_busy", 64'(busy_o[s]), 64'd0);
         chk("reset_data", d_o[s], 64'd0);
         chk("reset_ready", 64'(rdy_o[s]), 64'd0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int s = 0; s < 2; s++) chk("ready_first_cycle", 64'(rdy_o[s]), 64'd1);
      @(posedge clk);
      #1;

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 5; i++) single_op(s, tbl[i]);
         back_to_back(s);
         backpressure(s);
         reset_mid(s);
      end

`ifdef SEED_F_OPCNT_EN
      rst_n = 1'b0;
      #1;
      chk("opcnt_reset", 64'(cnt_o[1]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rdy_in[1] = 1'b1;
      v_in[1] = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      v_in[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("opcnt_full", 64'(cnt_o[1]), 64'hFFFF);
      obs_d[1].delete();
      obs_t[1].delete();
      send(1, 64'h1, 64'h2);
      drain(1, 0);
      chk("opcnt_wrap", 64'(cnt_o[1]), 64'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seed_f_pipe.md
SEED_F_PIPE -- requirements
Module: seed_f_pipe

Interface
REQ-001 The block SHALL have one parameter per line as follows:
- G_UNITS, default 3, number of G-function instances; legal values 1 (iterative) or 3 (pipelined).
REQ-002 The block SHALL have the following ports, one per line:
- i_Clk  input  1  single clock; all state changes on its rising edge.
- i_Rst_n  input  1  reset, asynchronous, active-low.
- i_Valid  input  1  input operand valid.
- o_Ready  output  1  block can accept an operand this cycle.
- i_Data  input  64  F-function data half-block, {C, D}.
- i_Key  input  64  round key, {Kc, Kd}.
- o_Valid  output  1  result valid.
- i_Ready  input  1  downstream accepts the result.
- o_Data  output  64  F-function result.
- o_Busy  output  1  at least one operation in flight or held.
REQ-003 Clock and reset SHALL be exactly one clock, i_Clk, and an asynchronous active-low reset, i_Rst_n.

Function
REQ-004 Math: C=i_Data[63:32]^i_Key[63:32]; D=i_Data[31:0]^i_Key[31:0]; t0=G(C^D); t1=G(C+t0); t2=G(t1+t0); o_Data={t1+t2, t2}; all "+" mod 2^32.
REQ-005 An input transfer SHALL occur when i_Valid&&o_Ready; an output transfer SHALL occur when o_Valid&&i_Ready.
REQ-006 Operands SHALL be captured on the transfer edge; later changes to i_Data/i_Key SHALL NOT affect that operation.
REQ-007 G_UNITS=1 SHALL use an FSM with states IDLE, G0, G1, G2, HOLD.
- IDLE->G0 on input transfer.
- G0->G1->G2 unconditionally, one G evaluation per state.
- G2->HOLD.
- HOLD->IDLE on output transfer.
REQ-008 G_UNITS=1: o_Ready=1 only in IDLE; o_Valid=1 only in HOLD; latency SHALL be 4 cycles from the input-transfer edge to o_Valid high.
REQ-009 G_UNITS=1: a new operand SHALL NOT be accepted in the cycle HOLD exits.
REQ-010 G_UNITS=3 SHALL be a 3-stage pipeline (stage k computes tk) with valid bits per stage; latency SHALL be 3 cycles.
REQ-011 G_UNITS=3: throughput SHALL be one operation per cycle while i_Ready=1.
REQ-012 G_UNITS=3: o_Ready SHALL be !stage3_valid||i_Ready.
- The whole pipeline SHALL advance only when o_Ready=1.
- Bubbles SHALL NOT be collapsed.
REQ-013 o_Data SHALL hold stable while o_Valid=1 and i_Ready=0.
REQ-014 o_Busy SHALL equal the OR of all stage/FSM occupancy flags.
REQ-015 Results SHALL emerge in acceptance order; no operation SHALL be dropped or duplicated.

Reset
REQ-016 Reset assertion SHALL, asynchronously:
- force FSM to IDLE and clear all stage valids, discarding in-flight operations;
- drive o_Valid=0, o_Busy=0, o_Data=0, and the counter (if present) to 0.
REQ-017 o_Ready SHALL be 0 while i_Rst_n=0 and 1 in the first cycle after deassertion.

Configuration
REQ-018 Macro SEED_F_OPCNT_EN SHALL control an operation counter.
- Defined: add output o_OpCnt [15:0], incremented on each output transfer, wrapping 0xFFFF->0x0000.
- Undefined: port and logic absent; all other behaviour identical.

Structure
REQ-019 Shared package seed_pkg SHALL hold:
- the FSM state enum;
- width constants (WORD=32, HALF=64);
- legal G_UNITS values.
REQ-020 The existing G-function module SHALL be the only sub-module, instantiated G_UNITS times; in G_UNITS=1 its input SHALL be muxed by FSM state.
REQ-021 Elaboration SHALL fail for G_UNITS not in {1,3}.

Verification
REQ-022 The bench SHALL cover these scenarios, each checked against the golden C model of REQ-004 for both G_UNITS values:
- Single op: i_Data=0x0123456789ABCDEF, i_Key=0xFEDCBA9876543210, i_Ready=1 -> o_Valid after 3 (pipelined) / 4 (iterative) cycles, o_Data matches model, o_Busy then 0.
- Back-to-back: 8 ops with consecutive i_Valid -> pipelined: 8 results on 8 consecutive cycles; iterative: one result every 5 cycles; all in order.
- Backpressure: i_Ready=0 for 10 cycles with result pending -> o_Data stable, o_Ready=0 once full, no loss after release.
- Reset mid-operation: assert i_Rst_n=0 one cycle after acceptance -> o_Valid=0 immediately; post-reset op with i_Data=0, i_Key=0 correct.
- Carry boundary: C=0xFFFFFFFF, D=0x00000000, key=0 -> mod-2^32 wrap matches model.
- SEED_F_OPCNT_EN: preload 65535 transfers -> o_OpCnt=0xFFFF; next transfer -> 0x0000.
